jk_bank_driver: RTL and testbench
=================================

# jk_bank_driver

Controller that drives an external bank of `N` JK flip-flops (the irrigation controller's valve and state registers) to a requested target value. It translates each target into per-bit J/K excitation, holds it for exactly one clock, then reads back the bank outputs and confirms the result. On mismatch it retries a bounded number of times, then flags an error. It sits between the irrigation sequencing logic (request side) and the JK register bank (J/K out, Q feedback in).

## Interface
- `N`, 4: width of the JK bank.
- `USE_TOGGLE`, 0: 0 selects set/reset excitation (10/01); 1 selects toggle excitation (11) for differing bits.
- `MAX_RETRY`, 2: number of re-drives after the first failed check. Legal range is 0..15.
- `CHECK_DELAY`, 1: number of cycles to wait after the drive before Q is compared. Legal range is 1..15.

Ports (name, direction, width, meaning):
- `clk` in 1: clock, rising edge.
- `preset` in 1: reset, asynchronous, active-high.
- `req_valid` in 1: a target is offered.
- `req_target` in N: requested bank value.
- `req_ready` out 1: the block can accept a request.
- `q_fb` in N: Q outputs of the JK bank.
- `j` out N: J excitation, registered.
- `k` out N: K excitation, registered.
- `busy` out 1: a request is in progress.
- `done` out 1: one-cycle pulse, Q matched the target.
- `err` out 1: one-cycle pulse, retries exhausted.

## Operation
- States:
  - IDLE: `req_ready`=1.
  - DRIVE: compute excitation.
  - SETTLE: excitation is applied.
  - CHECK: wait, then compare.
- Reset values while `preset`=1, effective immediately and asynchronously:
  - State is IDLE.
  - `j`=`k`=0, `req_ready`=1, `busy`=0, `done`=0, `err`=0.
  - Latched target, retry count and delay count are all 0.
- IDLE:
  - On `req_valid`&`req_ready`, latch `req_target` and clear the retry count.
  - Go to DRIVE; `req_ready`<=0, `busy`<=1.
- DRIVE: for each bit i, register the excitation from `q_fb[i]` versus `tgt[i]`, then go to SETTLE.
  - Equal: `j`=0, `k`=0.
  - 0 to 1: `j`=1, `k`=0 when `USE_TOGGLE`=0; `j`=1, `k`=1 when `USE_TOGGLE`=1.
  - 1 to 0: `j`=0, `k`=1 when `USE_TOGGLE`=0; `j`=1, `k`=1 when `USE_TOGGLE`=1.
- SETTLE: `j`/`k` are visible to the bank for exactly this one cycle. At the closing edge, `j`<=0, `k`<=0, clear the delay count, go to CHECK.
- CHECK: increment the delay count each edge. On the edge where the count reaches `CHECK_DELAY`, compare `q_fb` to the target:
  - Match: `done`<=1, `busy`<=0, `req_ready`<=1, go to IDLE.
  - Mismatch and retry count < `MAX_RETRY`: increment the retry count, go to DRIVE. Excitation is recomputed from the current `q_fb`.
  - Mismatch and retry count = `MAX_RETRY`: `err`<=1, `busy`<=0, `req_ready`<=1, go to IDLE.
- `done` and `err` are never high together, and each is high for one cycle only.
- `req_valid` and `req_target` are ignored while `busy`=1. The latched target is stable for the whole request.
- A request offered in the same cycle that `done` or `err` is high is accepted, because `req_ready`=1 in that cycle.
- `preset` asserted mid-request aborts it: `j`/`k` drop to 0 immediately, and no `done`/`err` pulse is produced.
- A target equal to the current Q still runs a full cycle: excitation is 00, then `done`.
- Retry count width is 4 bits; delay count width is 4 bits.

## Timing
- E0 is the acceptance edge.
- One attempt lasts 2+`CHECK_DELAY` cycles.
- With defaults: `j`/`k` are valid between E1 and E2, the compare is at E3, and `done` is high in the cycle after E3. Latency from acceptance to `done` is 3 cycles.
- Failure latency is (`MAX_RETRY`+1)·(2+`CHECK_DELAY`) cycles. With defaults, `err` is high after E9.
- The bank is assumed to update on the same `clk` edge that closes SETTLE. A `q_fb` that settles later must be covered by `CHECK_DELAY`.

## Test plan
- Reset: assert `preset` mid-SETTLE with `j`=1000 → `j`=`k`=0000 and `req_ready`=1 within the same cycle; no `done`.
- Set/reset, modelled bank, Q=0101, target 1100, `USE_TOGGLE`=0 → `j`=1000, `k`=0001 for one cycle; Q=1100; `done` 3 cycles after accept.
- Toggle, `USE_TOGGLE`=1, Q=0101, target 1100 → `j`=`k`=1001 for one cycle; Q=1100; `done`.
- Stuck fault: `q_fb` held at 0000, target 0011 → three drive pulses (`j`=0011) at attempts starting E1, E4, E7; `err` after E9; `done` never asserted.
- Retry recovery: bank ignores the first drive and obeys the second → `done` after E6, `err` never asserted.
- Handshake: `req_valid` held high with a changing target while `busy` → only the first target is applied. Back-to-back accept in the `done` cycle → the second request starts at the next edge.

Source files
------------

// File: rtl/jk_bank_driver.sv
// jk_bank_driver: drives an external bank of N JK flip-flops to a requested
// target value, verifies the result through Q feedback and retries a bounded
// number of times before flagging an error.
//
// Ports:
//   clk        - clock, rising edge
//   preset     - asynchronous active-high reset
//   req_valid  - a target is offered
//   req_target - requested bank value (N bits)
//   req_ready  - request can be accepted (registered)
//   q_fb       - Q outputs of the JK bank (N bits)
//   j, k       - per-bit JK excitation (registered, N bits each)
//   busy       - request in progress (registered)
//   done       - one-cycle pulse, bank matched the target (registered)
//   err        - one-cycle pulse, retries exhausted (registered)
module jk_bank_driver #(
    parameter int unsigned N           = 4,
    parameter int unsigned USE_TOGGLE  = 0,
    parameter int unsigned MAX_RETRY   = 2,
    parameter int unsigned CHECK_DELAY = 1
) (
    input  logic         clk,
    input  logic         preset,
    input  logic         req_valid,
    input  logic [N-1:0] req_target,
    output logic         req_ready,
    input  logic [N-1:0] q_fb,
    output logic [N-1:0] j,
    output logic [N-1:0] k,
    output logic         busy,
    output logic         done,
    output logic         err
);

    localparam int unsigned CNT_W = 4;
    localparam logic [CNT_W-1:0] MAX_RETRY_C   = CNT_W'(MAX_RETRY);
    localparam logic [CNT_W-1:0] CHECK_DELAY_C = CNT_W'(CHECK_DELAY);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DRIVE  = 2'd1,
        SETTLE = 2'd2,
        CHECK  = 2'd3
    } state_e;

    state_e           state_q, state_d;
    logic [N-1:0]     tgt_q, tgt_d;
    logic [CNT_W-1:0] retry_q, retry_d;
    logic [CNT_W-1:0] dly_q, dly_d;
    logic [N-1:0]     j_q, j_d;
    logic [N-1:0]     k_q, k_d;
    logic             ready_q, ready_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             err_q, err_d;

    logic [N-1:0]     diff;
    logic [CNT_W-1:0] dly_inc;

    // Bits whose current Q differs from the latched target.
    assign diff    = q_fb ^ tgt_q;
    assign dly_inc = dly_q + CNT_W'(1);

    // Next-state and registered-output logic.
    always_comb begin
        state_d = state_q;
        tgt_d   = tgt_q;
        retry_d = retry_q;
        dly_d   = dly_q;
        j_d     = j_q;
        k_d     = k_q;
        ready_d = ready_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        err_d   = 1'b0;

        case (state_q)
            IDLE: begin
                if (req_valid && ready_q) begin
                    tgt_d   = req_target;
                    retry_d = '0;
                    ready_d = 1'b0;
                    busy_d  = 1'b1;
                    state_d = DRIVE;
                end
            end
            DRIVE: begin
                // Toggle mode excites 11 on every differing bit; set/reset
                // mode picks 10 or 01 from the target direction.
                if (USE_TOGGLE != 0) begin
                    j_d = diff;
                    k_d = diff;
                end else begin
                    j_d = diff & tgt_q;
                    k_d = diff & ~tgt_q;
                end
                state_d = SETTLE;
            end
            SETTLE: begin
                j_d     = '0;
                k_d     = '0;
                dly_d   = '0;
                state_d = CHECK;
            end
            CHECK: begin
                dly_d = dly_inc;
                if (dly_inc == CHECK_DELAY_C) begin
                    if (q_fb == tgt_q) begin
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                        ready_d = 1'b1;
                        state_d = IDLE;
                    end else if (retry_q < MAX_RETRY_C) begin
                        retry_d = retry_q + CNT_W'(1);
                        state_d = DRIVE;
                    end else begin
                        err_d   = 1'b1;
                        busy_d  = 1'b0;
                        ready_d = 1'b1;
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers; preset forces the idle, undriven bank state.
    always_ff @(posedge clk or posedge preset) begin
        if (preset) begin
            state_q <= IDLE;
            tgt_q   <= '0;
            retry_q <= '0;
            dly_q   <= '0;
            j_q     <= '0;
            k_q     <= '0;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            tgt_q   <= tgt_d;
            retry_q <= retry_d;
            dly_q   <= dly_d;
            j_q     <= j_d;
            k_q     <= k_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign j         = j_q;
    assign k         = k_q;
    assign req_ready = ready_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;

endmodule

// File: tb/tb_jk_bank_driver.sv
// Bench for jk_bank_driver: two instances (set/reset and toggle excitation),
// each connected to a behavioural JK bank model with optional fault modes.
module tb_jk_bank_driver;

    logic clk = 1'b0;
    logic preset;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Instance 0: set/reset excitation, default timing.
    logic       req_valid0;
    logic [3:0] req_target0;
    logic       req_ready0, busy0, done0, err0;
    logic [3:0] j0, k0, bq0;

    // Instance 1: toggle excitation.
    logic       req_valid1;
    logic [3:0] req_target1;
    logic       req_ready1, busy1, done1, err1;
    logic [3:0] j1, k1, bq1;

    jk_bank_driver #(.N(4), .USE_TOGGLE(0), .MAX_RETRY(2), .CHECK_DELAY(1)) dut0 (
        .clk(clk), .preset(preset), .req_valid(req_valid0), .req_target(req_target0),
        .req_ready(req_ready0), .q_fb(bq0), .j(j0), .k(k0),
        .busy(busy0), .done(done0), .err(err0)
    );

    jk_bank_driver #(.N(4), .USE_TOGGLE(1), .MAX_RETRY(2), .CHECK_DELAY(1)) dut1 (
        .clk(clk), .preset(preset), .req_valid(req_valid1), .req_target(req_target1),
        .req_ready(req_ready1), .q_fb(bq1), .j(j1), .k(k1),
        .busy(busy1), .done(done1), .err(err1)
    );

    // Bank 0 model. mode0: 0 normal, 1 stuck (Q frozen), 2 ignore first drive.
    logic       load0;
    logic [3:0] load_val0;
    int         mode0;
    logic       ignored0;
    always @(posedge clk) begin
        if (load0) begin
            bq0      <= load_val0;
            ignored0 <= 1'b0;
        end else if (mode0 != 1 && (j0 | k0) != 4'b0000) begin
            if (mode0 == 2 && !ignored0) ignored0 <= 1'b1;
            else bq0 <= (j0 & ~bq0) | (~k0 & bq0);
        end
    end

    // Bank 1 model, always obeys.
    logic       load1;
    logic [3:0] load_val1;
    always @(posedge clk) begin
        if (load1) bq1 <= load_val1;
        else       bq1 <= (j1 & ~bq1) | (~k1 & bq1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_bank0(input logic [3:0] v, input int m);
        load0 = 1'b1; load_val0 = v; mode0 = m;
        tick();
        load0 = 1'b0;
    endtask

    task automatic test_reset();
        // Power-on reset values.
        n_checks++; if ({req_ready0, busy0, done0, err0} !== 4'b1000) begin n_fail++; $display("FAIL reset_ctrl got %b want 1000", {req_ready0, busy0, done0, err0}); end
        n_checks++; if ({j0, k0} !== 8'h00) begin n_fail++; $display("FAIL reset_jk got %h want 00", {j0, k0}); end
        preset = 1'b0;
        tick();
        // Abort mid-SETTLE: Q=0101, target 1101 gives j=1000.
        load_bank0(4'b0101, 0);
        req_valid0 = 1'b1; req_target0 = 4'b1101;
        tick();                                   // E0
        req_valid0 = 1'b0;
        tick();                                   // E1, now in SETTLE
        n_checks++; if (j0 !== 4'b1000) begin n_fail++; $display("FAIL abort_pre_j got %b want 1000", j0); end
        #2 preset = 1'b1;
        #1;
        n_checks++; if ({j0, k0} !== 8'h00) begin n_fail++; $display("FAIL abort_jk got %h want 00", {j0, k0}); end
        n_checks++; if ({req_ready0, busy0} !== 2'b10) begin n_fail++; $display("FAIL abort_ready_busy got %b want 10", {req_ready0, busy0}); end
        tick();
        preset = 1'b0;
        for (int c = 0; c < 5; c++) begin
            tick();
            n_checks++; if ({done0, err0} !== 2'b00) begin n_fail++; $display("FAIL abort_no_pulse cyc %0d got %b want 00", c, {done0, err0}); end
        end
    endtask

    task automatic test_set_reset();
        load_bank0(4'b0101, 0);
        req_valid0 = 1'b1; req_target0 = 4'b1100;
        tick();                                   // E0
        req_valid0 = 1'b0;
        n_checks++; if ({req_ready0, busy0} !== 2'b01) begin n_fail++; $display("FAIL sr_accept got %b want 01", {req_ready0, busy0}); end
        tick();                                   // E1
        n_checks++; if (j0 !== 4'b1000 || k0 !== 4'b0001) begin n_fail++; $display("FAIL sr_excite got j=%b k=%b want j=1000 k=0001", j0, k0); end
        tick();                                   // E2
        n_checks++; if ({j0, k0} !== 8'h00) begin n_fail++; $display("FAIL sr_release got %h want 00", {j0, k0}); end
        n_checks++; if (bq0 !== 4'b1100) begin n_fail++; $display("FAIL sr_bank got %b want 1100", bq0); end
        n_checks++; if (done0 !== 1'b0) begin n_fail++; $display("FAIL sr_early_done got %b want 0", done0); end
        tick();                                   // E3
        n_checks++; if ({done0, err0, busy0, req_ready0} !== 4'b1001) begin n_fail++; $display("FAIL sr_done got %b want 1001", {done0, err0, busy0, req_ready0}); end
        tick();
        n_checks++; if (done0 !== 1'b0) begin n_fail++; $display("FAIL sr_done_pulse got %b want 0", done0); end
    endtask

    task automatic test_toggle();
        load1 = 1'b1; load_val1 = 4'b0101;
        tick();
        load1 = 1'b0;
        req_valid1 = 1'b1; req_target1 = 4'b1100;
        tick();                                   // E0
        req_valid1 = 1'b0;
        tick();                                   // E1
        n_checks++; if (j1 !== 4'b1001 || k1 !== 4'b1001) begin n_fail++; $display("FAIL tg_excite got j=%b k=%b want 1001/1001", j1, k1); end
        tick();                                   // E2
        n_checks++; if (bq1 !== 4'b1100 || {j1, k1} !== 8'h00) begin n_fail++; $display("FAIL tg_bank got q=%b jk=%h want 1100/00", bq1, {j1, k1}); end
        tick();                                   // E3
        n_checks++; if ({done1, err1} !== 2'b10) begin n_fail++; $display("FAIL tg_done got %b want 10", {done1, err1}); end
    endtask

    task automatic test_stuck();
        load_bank0(4'b0000, 1);
        req_valid0 = 1'b1; req_target0 = 4'b0011;
        tick();                                   // E0
        req_valid0 = 1'b0;
        for (int e = 1; e <= 10; e++) begin
            logic [3:0] ej;
            tick();
            ej = (e == 1 || e == 4 || e == 7) ? 4'b0011 : 4'b0000;
            n_checks++; if (j0 !== ej || k0 !== 4'b0000) begin n_fail++; $display("FAIL stuck_jk E%0d got j=%b k=%b want j=%b k=0000", e, j0, k0, ej); end
            n_checks++; if (err0 !== (e == 9) || done0 !== 1'b0) begin n_fail++; $display("FAIL stuck_flags E%0d got err=%b done=%b want err=%b done=0", e, err0, done0, e == 9); end
        end
        n_checks++; if ({req_ready0, busy0} !== 2'b10) begin n_fail++; $display("FAIL stuck_idle got %b want 10", {req_ready0, busy0}); end
    endtask

    task automatic test_retry_recovery();
        load_bank0(4'b0000, 2);
        req_valid0 = 1'b1; req_target0 = 4'b0011;
        tick();                                   // E0
        req_valid0 = 1'b0;
        for (int e = 1; e <= 8; e++) begin
            tick();
            n_checks++; if (done0 !== (e == 6) || err0 !== 1'b0) begin n_fail++; $display("FAIL retry E%0d got done=%b err=%b want done=%b err=0", e, done0, err0, e == 6); end
        end
        n_checks++; if (bq0 !== 4'b0011) begin n_fail++; $display("FAIL retry_bank got %b want 0011", bq0); end
    endtask

    task automatic test_equal_target();
        load_bank0(4'b1111, 0);
        req_valid0 = 1'b1; req_target0 = 4'b1111;
        tick();                                   // E0
        req_valid0 = 1'b0;
        tick();                                   // E1
        n_checks++; if ({j0, k0} !== 8'h00 || busy0 !== 1'b1) begin n_fail++; $display("FAIL eq_excite got jk=%h busy=%b want 00/1", {j0, k0}, busy0); end
        tick(); tick();                           // E3
        n_checks++; if (done0 !== 1'b1) begin n_fail++; $display("FAIL eq_done got %b want 1", done0); end
    endtask

    task automatic test_back_to_back();
        load_bank0(4'b0000, 0);
        req_valid0 = 1'b1; req_target0 = 4'b0011;
        tick();                                   // E0
        req_target0 = 4'b1111;                    // valid stays high while busy
        tick();                                   // E1
        n_checks++; if (j0 !== 4'b0011) begin n_fail++; $display("FAIL b2b_first_target got j=%b want 0011", j0); end
        tick(); tick();                           // E3
        n_checks++; if ({done0, req_ready0} !== 2'b11) begin n_fail++; $display("FAIL b2b_done got %b want 11", {done0, req_ready0}); end
        tick();                                   // E4, second request accepted
        req_valid0 = 1'b0;
        n_checks++; if ({done0, req_ready0, busy0} !== 3'b001) begin n_fail++; $display("FAIL b2b_accept got %b want 001", {done0, req_ready0, busy0}); end
        tick();                                   // E5
        n_checks++; if (j0 !== 4'b1100 || k0 !== 4'b0000) begin n_fail++; $display("FAIL b2b_second got j=%b k=%b want 1100/0000", j0, k0); end
        tick(); tick();                           // E7
        n_checks++; if (done0 !== 1'b1 || bq0 !== 4'b1111) begin n_fail++; $display("FAIL b2b_second_done got done=%b q=%b want 1/1111", done0, bq0); end
    endtask

    initial begin
        preset      = 1'b1;
        req_valid0  = 1'b0; req_target0 = 4'b0000;
        req_valid1  = 1'b0; req_target1 = 4'b0000;
        load0 = 1'b0; load_val0 = 4'b0000; mode0 = 0;
        load1 = 1'b0; load_val1 = 4'b0000;
        #1;
        test_reset();
        test_set_reset();
        test_toggle();
        test_stuck();
        test_retry_recovery();
        test_equal_target();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
